aes_mode_chain_ctrl: RTL and testbench
======================================

# aes_mode_chain_ctrl

Block-chaining controller for the AES encrypt datapath. It sits between the plaintext stream and the AES core, directly upstream of the 128-bit feedback register. It forms the core input from plaintext and the feedback value and forms ciphertext from the core output. It also drives the feedback register's `load_iv`/`update` strobes and `data_in` for ECB, CBC, CTR and OFB encryption.

## Interface
- `CTR_W`, default 32: width of the CTR-mode counter field (low bits of the block); increments wrap modulo 2^CTR_W.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a message; ignored unless in IDLE.
- `mode` in 2: 00 ECB, 01 CBC, 10 CTR, 11 OFB; sampled on accepted `start`.
- `s_valid` in 1 / `s_ready` out 1 / `s_data` in 128 / `s_last` in 1: plaintext stream.
- `m_valid` out 1 / `m_ready` in 1 / `m_data` out 128: ciphertext stream.
- `core_start` out 1 / `core_in` out 128: AES core launch pulse and block.
- `core_done` in 1 / `core_out` in 128: AES core completion pulse and result.
- `fb_in` in 128: current feedback register value.
- `fb_load_iv` out 1 / `fb_update` out 1 / `fb_data` out 128: feedback register controls and data.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, LOAD_IV, ACCEPT, ISSUE, WAIT, OUTPUT.
- IDLE, `start`=1: latch `mode`. ECB goes to ACCEPT; other modes go to LOAD_IV.
- LOAD_IV: `fb_load_iv`=1 for exactly one cycle, then ACCEPT.
- ACCEPT: `s_ready`=1. On `s_valid`, latch `s_data` into `pt_r`, latch `s_last`, and go to ISSUE.
- ISSUE: `core_start`=1 for one cycle. `core_in` is registered and held until `core_done`, then WAIT.
  - ECB: `pt_r`.
  - CBC: `pt_r ^ fb_in`.
  - CTR and OFB: `fb_in`.
- WAIT: on `core_done`, register `m_data`, pulse `fb_update` for one cycle, and go to OUTPUT.
  - ECB: `m_data` = `core_out`; no `fb_update`.
  - CBC: `m_data` = `core_out`; `fb_data` = `core_out`.
  - CTR: `m_data` = `pt_r ^ core_out`; `fb_data` = `{fb_in[127:CTR_W], fb_in[CTR_W-1:0]+1}`.
  - OFB: `m_data` = `pt_r ^ core_out`; `fb_data` = `core_out`.
- OUTPUT: `m_valid`=1 until `m_ready`. `m_data` stays stable while stalled. On handshake, go to IDLE if the latched last flag is set, else to ACCEPT.
- `core_done` outside WAIT is ignored.
- `start` outside IDLE is ignored.
- `mode` changes mid-message have no effect.
- `reset_n` low, at any time, forces IDLE and all outputs to 0. An in-flight block is discarded. The feedback register is not reloaded until the next `start`.

## Timing
- Reset values: `s_ready`, `m_valid`, `core_start`, `fb_load_iv`, `fb_update`, `busy` = 0; `m_data`, `core_in`, `fb_data` = 0.
- `start` at cycle 0 (non-ECB): `fb_load_iv` at cycle 1, `s_ready` at cycle 2. For ECB, `s_ready` is at cycle 1.
- Plaintext handshake at cycle T: `core_start` at T+1.
- `core_done` at cycle D: `m_valid`, `m_data`, `fb_update` and `fb_data` are all valid at D+1. The feedback register value is visible on `fb_in` at D+2.
- Earliest next `core_start` is D+3, which requires `m_ready` at D+1 and `s_valid` at D+2. This guarantees `fb_in` is updated before reuse.
- All outputs are registered; there are no combinational in-to-out paths.

## Structure
- Shared package `aes_mode_pkg` holds the mode encodings (ECB/CBC/CTR/OFB), the state enum, and the block width constant of 128.
- Optional sub-module `aes_ctr_inc` provides the parameterised CTR_W-bit wrap increment with upper bits passed through. Everything else stays in the single module.

## Test plan
The bench uses a behavioural AES-128 core with 10-cycle latency and key 2b7e151628aed2a6abf7158809cf4f3c.

- **ECB:** PT 6bc1bee22e409f96e93d7e117393172a -> `m_data` 3ad77bb40d7a3660a89ecaf32466ef97; `fb_load_iv` and `fb_update` never asserted.
- **CBC:** IV 000102030405060708090a0b0c0d0e0f, same PT -> 7649abac8119b246cee98e9b12e9197d; `fb_data` equals the same value.
- **CTR:** IV f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, same PT -> 874d6191b620e3261bef6864990db6ce; `fb_data` f0f1f2f3f4f5f6f7f8f9fafbfcfdff00.
- **CTR wrap:** IV with low 32 bits ffffffff -> `fb_data` low 32 bits 00000000, upper 96 bits unchanged.
- **OFB:** same IV as CBC and same PT -> 3b3fd92eb72dad20333449f8e83cfb4a. Then hold `m_ready` low for 5 cycles: `m_data` stable, `s_ready` low.
- **Reset and stray inputs:** assert `reset_n` low during WAIT -> all outputs 0 next edge and IDLE; a later `core_done` is ignored. A `start` pulse while `busy` has no effect.

Source files
------------

// File: rtl/aes_mode_chain_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aes_mode_pkg
// Brief   : Mode encodings, controller state enum and block width shared by
//           the AES block-chaining controller, its interface and sub-modules.
// Revision: 1.0 - initial release
// ============================================================================
package aes_mode_pkg;

    localparam int c_blk_w = 128;

    typedef enum logic [1:0] {
        MODE_ECB = 2'b00,
        MODE_CBC = 2'b01,
        MODE_CTR = 2'b10,
        MODE_OFB = 2'b11
    } aes_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_IV = 3'd1,
        ST_ACCEPT  = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_WAIT    = 3'd4,
        ST_OUTPUT  = 3'd5
    } chain_state_e;

endpackage
`default_nettype wire

// File: rtl/aes_mode_chain_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : aes_mode_chain_ctrl_if
// Brief   : Plaintext/ciphertext streams, AES core launch/result and feedback
//           register controls around the chaining controller.
// Revision: 1.0 - initial release
// ============================================================================
interface aes_mode_chain_ctrl_if;
    import aes_mode_pkg::*;

    logic               s_valid;
    logic               s_ready;
    logic [c_blk_w-1:0] s_data;
    logic               s_last;

    logic               m_valid;
    logic               m_ready;
    logic [c_blk_w-1:0] m_data;

    logic               core_start;
    logic [c_blk_w-1:0] core_in;
    logic               core_done;
    logic [c_blk_w-1:0] core_out;

    logic [c_blk_w-1:0] fb_in;
    logic               fb_load_iv;
    logic               fb_update;
    logic [c_blk_w-1:0] fb_data;

    // Controller side
    modport master (
        input  s_valid, s_data, s_last,
        output s_ready,
        output m_valid, m_data,
        input  m_ready,
        output core_start, core_in,
        input  core_done, core_out,
        input  fb_in,
        output fb_load_iv, fb_update, fb_data
    );

    // Surrounding datapath side
    modport slave (
        output s_valid, s_data, s_last,
        input  s_ready,
        input  m_valid, m_data,
        output m_ready,
        input  core_start, core_in,
        output core_done, core_out,
        output fb_in,
        input  fb_load_iv, fb_update, fb_data
    );

endinterface
`default_nettype wire

// File: rtl/aes_mode_chain_ctrl_ctr_inc.sv
`default_nettype none
// ============================================================================
// Module  : aes_ctr_inc
// Brief   : Increments the low CTR_W bits of a block modulo 2^CTR_W and
//           passes the upper bits through unchanged.
// Revision: 1.0 - initial release
// ============================================================================
module aes_ctr_inc #(
    parameter int CTR_W = 32,
    parameter int BLK_W = 128
) (
    input  logic [BLK_W-1:0] i_blk,
    output logic [BLK_W-1:0] o_blk
);

    generate
        if (CTR_W >= BLK_W) begin : g_full
            assign o_blk = i_blk + BLK_W'(1);
        end else begin : g_part
            assign o_blk = {i_blk[BLK_W-1:CTR_W], i_blk[CTR_W-1:0] + CTR_W'(1)};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/aes_mode_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : aes_mode_chain_ctrl
// Brief   : ECB/CBC/CTR/OFB encrypt chaining controller between the plaintext
//           stream, the AES core and the 128-bit feedback register.
// Revision: 1.0 - initial release
// ============================================================================
module aes_mode_chain_ctrl
    import aes_mode_pkg::*;
#(
    parameter int CTR_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  busy,
    aes_mode_chain_ctrl_if.master bus
);

    chain_state_e       r_state,    w_state_nxt;
    aes_mode_e          r_mode,     w_mode_nxt;
    logic [c_blk_w-1:0] r_pt,       w_pt_nxt;
    logic               r_last,     w_last_nxt;
    logic [c_blk_w-1:0] r_m_data,   w_m_data_nxt;
    logic [c_blk_w-1:0] r_core_in,  w_core_in_nxt;
    logic [c_blk_w-1:0] r_fb_data,  w_fb_data_nxt;
    logic               r_s_ready,  w_s_ready_nxt;
    logic               r_m_valid,  w_m_valid_nxt;
    logic               r_core_start, w_core_start_nxt;
    logic               r_fb_load_iv, w_fb_load_iv_nxt;
    logic               r_fb_update,  w_fb_update_nxt;
    logic               r_busy,     w_busy_nxt;
    logic [c_blk_w-1:0] w_ctr_next;

    aes_ctr_inc #(
        .CTR_W (CTR_W),
        .BLK_W (c_blk_w)
    ) u_ctr_inc (
        .i_blk (bus.fb_in),
        .o_blk (w_ctr_next)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_pt_nxt      = r_pt;
        w_last_nxt    = r_last;
        w_m_data_nxt  = r_m_data;
        w_core_in_nxt = r_core_in;
        w_fb_data_nxt = r_fb_data;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_mode_nxt  = aes_mode_e'(mode);
                    w_state_nxt = (mode == MODE_ECB) ? ST_ACCEPT : ST_LOAD_IV;
                end
            end
            ST_LOAD_IV: w_state_nxt = ST_ACCEPT;
            ST_ACCEPT: begin
                if (bus.s_valid) begin
                    w_pt_nxt    = bus.s_data;
                    w_last_nxt  = bus.s_last;
                    w_state_nxt = ST_ISSUE;
                    // Core input is formed from s_data because pt_r loads on this same edge
                    case (r_mode)
                        MODE_ECB: w_core_in_nxt = bus.s_data;
                        MODE_CBC: w_core_in_nxt = bus.s_data ^ bus.fb_in;
                        MODE_CTR: w_core_in_nxt = bus.fb_in;
                        MODE_OFB: w_core_in_nxt = bus.fb_in;
                    endcase
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (bus.core_done) begin
                    w_state_nxt = ST_OUTPUT;
                    case (r_mode)
                        MODE_ECB: w_m_data_nxt = bus.core_out;
                        MODE_CBC: begin
                            w_m_data_nxt  = bus.core_out;
                            w_fb_data_nxt = bus.core_out;
                        end
                        MODE_CTR: begin
                            w_m_data_nxt  = r_pt ^ bus.core_out;
                            w_fb_data_nxt = w_ctr_next;
                        end
                        MODE_OFB: begin
                            w_m_data_nxt  = r_pt ^ bus.core_out;
                            w_fb_data_nxt = bus.core_out;
                        end
                    endcase
                end
            end
            ST_OUTPUT: begin
                if (bus.m_ready) begin
                    w_state_nxt = r_last ? ST_IDLE : ST_ACCEPT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so every output leaves a flop
    assign w_s_ready_nxt    = (w_state_nxt == ST_ACCEPT);
    assign w_m_valid_nxt    = (w_state_nxt == ST_OUTPUT);
    assign w_core_start_nxt = (w_state_nxt == ST_ISSUE);
    assign w_fb_load_iv_nxt = (w_state_nxt == ST_LOAD_IV);
    assign w_fb_update_nxt  = (r_state == ST_WAIT) && bus.core_done && (r_mode != MODE_ECB);
    assign w_busy_nxt       = (w_state_nxt != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_mode       <= MODE_ECB;
            r_pt         <= '0;
            r_last       <= 1'b0;
            r_m_data     <= '0;
            r_core_in    <= '0;
            r_fb_data    <= '0;
            r_s_ready    <= 1'b0;
            r_m_valid    <= 1'b0;
            r_core_start <= 1'b0;
            r_fb_load_iv <= 1'b0;
            r_fb_update  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mode       <= w_mode_nxt;
            r_pt         <= w_pt_nxt;
            r_last       <= w_last_nxt;
            r_m_data     <= w_m_data_nxt;
            r_core_in    <= w_core_in_nxt;
            r_fb_data    <= w_fb_data_nxt;
            r_s_ready    <= w_s_ready_nxt;
            r_m_valid    <= w_m_valid_nxt;
            r_core_start <= w_core_start_nxt;
            r_fb_load_iv <= w_fb_load_iv_nxt;
            r_fb_update  <= w_fb_update_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign bus.s_ready    = r_s_ready;
    assign bus.m_valid    = r_m_valid;
    assign bus.m_data     = r_m_data;
    assign bus.core_start = r_core_start;
    assign bus.core_in    = r_core_in;
    assign bus.fb_load_iv = r_fb_load_iv;
    assign bus.fb_update  = r_fb_update;
    assign bus.fb_data    = r_fb_data;
    assign busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_aes_mode_chain_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_aes_mode_chain_ctrl
// Brief   : Bench for the chaining controller with a 10-cycle AES-128 core
//           model and a feedback register model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_mode_chain_ctrl;
    import aes_mode_pkg::*;

    localparam int            c_ctr_w = 32;
    localparam logic [127:0]  c_key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0]  c_pt    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0]  c_pt2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0]  c_iv1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0]  c_iv2   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0]  c_ivw   = 128'hf0f1f2f3f4f5f6f7f8f9fafbffffffff;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [1:0] mode;
    logic       busy;

    aes_mode_chain_ctrl_if bus ();

    aes_mode_chain_ctrl #(.CTR_W(c_ctr_w)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .mode    (mode),
        .busy    (busy),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural AES-128 ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        logic [7:0] pw;
        inv = 8'h01;
        pw  = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, pw);
            pw = gmul(pw, pw);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [127:0] s;
        logic [127:0] key;
        key = c_key;
        rc  = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) st[i] = sbox(s[127-8*i -: 8]);
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    tmp[q+4*c] = st[q + 4*((c+q) % 4)];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    st[4*c]   = xt(tmp[4*c]) ^ xt(tmp[4*c+1]) ^ tmp[4*c+1] ^ tmp[4*c+2] ^ tmp[4*c+3];
                    st[4*c+1] = tmp[4*c] ^ xt(tmp[4*c+1]) ^ xt(tmp[4*c+2]) ^ tmp[4*c+2] ^ tmp[4*c+3];
                    st[4*c+2] = tmp[4*c] ^ tmp[4*c+1] ^ xt(tmp[4*c+2]) ^ xt(tmp[4*c+3]) ^ tmp[4*c+3];
                    st[4*c+3] = xt(tmp[4*c]) ^ tmp[4*c] ^ tmp[4*c+1] ^ tmp[4*c+2] ^ xt(tmp[4*c+3]);
                end
            end else begin
                st = tmp;
            end
            for (int i = 0; i < 16; i++) s[127-8*i -: 8] = st[i];
            s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    // ---------------- core and feedback register models ----------------
    logic         core_done_m = 1'b0;
    logic [127:0] core_out_m  = '0;
    logic [127:0] core_res    = '0;
    int           core_cnt    = 0;
    logic [127:0] fb_q        = '0;
    logic [127:0] iv_val      = '0;
    int           n_load      = 0;
    int           n_upd       = 0;
    int           n_done      = 0;

    always @(posedge clk) begin
        if (bus.core_start === 1'b1) begin
            core_cnt <= 10;
            core_res <= aes_enc(bus.core_in);
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
        end
        core_done_m <= (core_cnt == 1) && (bus.core_start !== 1'b1);
        if (core_cnt == 1) core_out_m <= core_res;
    end

    always @(posedge clk) begin
        if (bus.fb_load_iv === 1'b1)     fb_q <= iv_val;
        else if (bus.fb_update === 1'b1) fb_q <= bus.fb_data;
    end

    always @(negedge clk) begin
        if (bus.fb_load_iv === 1'b1) n_load <= n_load + 1;
        if (bus.fb_update === 1'b1)  n_upd  <= n_upd + 1;
        if (bus.core_done === 1'b1)  n_done <= n_done + 1;
    end

    assign bus.core_done = core_done_m;
    assign bus.core_out  = core_out_m;
    assign bus.fb_in     = fb_q;

    // ---------------- checking ----------------
    typedef struct {
        logic [127:0] ct;
        logic         fb_chk;
        logic [127:0] fb;
    } exp_t;

    typedef struct {
        logic [1:0]   md;
        logic [127:0] iv;
        logic [127:0] pt;
        logic [127:0] ct;
        logic         fb_chk;
        logic [127:0] fb;
        int           stall;
    } vec_t;

    exp_t sb [$];
    vec_t vt [5];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] md, input logic [127:0] iv, input logic [127:0] pt,
                                input logic [127:0] ct, input logic fc, input logic [127:0] fb,
                                input int st);
        vec_t v;
        v.md = md; v.iv = iv; v.pt = pt; v.ct = ct; v.fb_chk = fc; v.fb = fb; v.stall = st;
        return v;
    endfunction

    task automatic check_all_zero(input string name);
        chk({name, "_ctrl"}, {122'd0, bus.s_ready, bus.m_valid, bus.core_start,
                              bus.fb_load_iv, bus.fb_update, busy}, '0);
        chk({name, "_m_data"}, bus.m_data, '0);
        chk({name, "_core_in"}, bus.core_in, '0);
        chk({name, "_fb_data"}, bus.fb_data, '0);
    endtask

    task automatic start_msg(input logic [1:0] md, input logic [127:0] iv);
        iv_val = iv;
        start  = 1'b1;
        mode   = md;
        @(negedge clk);
        start  = 1'b0;
        mode   = md ^ 2'b11;
        chk1("load_iv_c1", bus.fb_load_iv, md != MODE_ECB);
        chk1("s_ready_c1", bus.s_ready, md == MODE_ECB);
        if (md != MODE_ECB) begin
            @(negedge clk);
            chk1("s_ready_c2", bus.s_ready, 1'b1);
        end
    endtask

    task automatic send_block(input logic [127:0] pt, input logic last, input int stall, input logic poke);
        exp_t         e;
        int           n;
        logic [127:0] held;
        bus.s_valid = 1'b1;
        bus.s_data  = pt;
        bus.s_last  = last;
        n = 0;
        while (bus.s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk1("s_ready_timeout", 1'b0, 1'b1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        chk1("core_start_t1", bus.core_start, 1'b1);
        if (poke) begin
            start = 1'b1;
            mode  = MODE_ECB;
            @(negedge clk);
            start = 1'b0;
            chk1("poke_busy", busy, 1'b1);
        end
        n = 0;
        while (bus.m_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk1("m_valid_timeout", 1'b0, 1'b1);
        if (sb.size() == 0) begin
            chki("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("m_data", bus.m_data, e.ct);
            chk1("fb_update", bus.fb_update, e.fb_chk);
            if (e.fb_chk) chk("fb_data", bus.fb_data, e.fb);
        end
        held = bus.m_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk1("stall_m_valid", bus.m_valid, 1'b1);
            chk("stall_m_data", bus.m_data, held);
            chk1("stall_s_ready", bus.s_ready, 1'b0);
            chk1("stall_fb_update", bus.fb_update, 1'b0);
        end
        bus.m_ready = 1'b1;
        @(negedge clk);
        bus.m_ready = 1'b0;
        chk1("m_valid_drop", bus.m_valid, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        int   l0;
        int   u0;
        exp_t e;
        l0 = n_load;
        u0 = n_upd;
        e.ct = v.ct; e.fb_chk = v.fb_chk; e.fb = v.fb;
        start_msg(v.md, v.iv);
        sb.push_back(e);
        send_block(v.pt, 1'b1, v.stall, 1'b0);
        @(negedge clk);
        chk1("busy_end", busy, 1'b0);
        chki("n_load_iv", n_load - l0, (v.md != MODE_ECB) ? 1 : 0);
        chki("n_update", n_upd - u0, v.fb_chk ? 1 : 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t         e;
        logic [127:0] ct2;
        logic         bad;
        int           l0;
        int           u0;
        int           d0;

        reset_n     = 1'b0;
        start       = 1'b0;
        mode        = 2'b00;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;

        vt[0] = mk(MODE_ECB, '0,    c_pt, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 1'b0, '0, 0);
        vt[1] = mk(MODE_CBC, c_iv1, c_pt, 128'h7649abac8119b246cee98e9b12e9197d, 1'b1,
                   128'h7649abac8119b246cee98e9b12e9197d, 0);
        vt[2] = mk(MODE_CTR, c_iv2, c_pt, 128'h874d6191b620e3261bef6864990db6ce, 1'b1,
                   128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00, 0);
        vt[3] = mk(MODE_OFB, c_iv1, c_pt, 128'h3b3fd92eb72dad20333449f8e83cfb4a, 1'b1,
                   128'h50fe67cc996d32b6da0937e99bafec60, 5);
        vt[4] = mk(MODE_CTR, c_ivw, c_pt, c_pt ^ aes_enc(c_ivw), 1'b1,
                   128'hf0f1f2f3f4f5f6f7f8f9fafb00000000, 0);

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk1("idle_busy", busy, 1'b0);

        for (int i = 0; i < 5; i++) run_vec(vt[i]);

        // Two-block CBC with a stray start during the first block
        l0 = n_load;
        u0 = n_upd;
        start_msg(MODE_CBC, c_iv1);
        e.ct = vt[1].ct; e.fb_chk = 1'b1; e.fb = vt[1].ct;
        sb.push_back(e);
        send_block(c_pt, 1'b0, 0, 1'b1);
        chk1("accept_next", bus.s_ready, 1'b1);
        ct2 = aes_enc(c_pt2 ^ vt[1].ct);
        e.ct = ct2; e.fb_chk = 1'b1; e.fb = ct2;
        sb.push_back(e);
        send_block(c_pt2, 1'b1, 0, 1'b0);
        @(negedge clk);
        chk1("cbc2_busy_end", busy, 1'b0);
        chki("cbc2_n_load_iv", n_load - l0, 1);
        chki("cbc2_n_update", n_upd - u0, 2);

        // Reset while the core is working; its late completion must be ignored
        start_msg(MODE_CBC, c_iv1);
        bus.s_valid = 1'b1;
        bus.s_data  = c_pt;
        bus.s_last  = 1'b1;
        @(negedge clk);
        bus.s_valid = 1'b0;
        chk1("rst_core_start", bus.core_start, 1'b1);
        repeat (3) @(negedge clk);
        chk1("rst_in_wait_busy", busy, 1'b1);
        d0 = n_done;
        reset_n = 1'b0;
        @(negedge clk);
        check_all_zero("reset_wait");
        reset_n = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            bad = bad | busy | bus.m_valid | bus.fb_update | bus.core_start | bus.s_ready;
        end
        chk1("stray_done_ignored", bad, 1'b0);
        chki("stray_done_seen", n_done - d0, 1);

        run_vec(vt[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
